// File: rtl/flatten_serializer_block.sv
// flatten_serializer_block
//   Captures one pooled frame (DIMENSION channels in parallel per pixel, framed
//   by sop/eop) into local RAM, then replays it as a channel-major scalar stream
//   under a valid/ready handshake.
// Ports
//   clk, rst_n (async, active-low), clk_en (freezes the block when 0)
//   i_data/i_valid/i_sop/i_eop : input pixel beats, accepted while o_ready=1
//   o_data/o_index/o_sop/o_eop/o_valid, i_ready : flattened output stream
//   o_err : one-cycle pulse on a framing error
module flatten_serializer_block #(
  parameter  int PIX_WIDTH  = 8,
  parameter  int IMG_WIDTH  = 14,
  parameter  int IMG_HEIGHT = 14,
  parameter  int DIMENSION  = 4,
  localparam int FRAME      = IMG_WIDTH * IMG_HEIGHT,
  localparam int TOTAL      = DIMENSION * FRAME,
  localparam int IDX_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_en,
  input  logic [DIMENSION-1:0][PIX_WIDTH-1:0]  i_data,
  input  logic                                 i_valid,
  input  logic                                 i_sop,
  input  logic                                 i_eop,
  output logic                                 o_ready,
  output logic [PIX_WIDTH-1:0]                 o_data,
  output logic                                 o_valid,
  output logic                                 o_sop,
  output logic                                 o_eop,
  output logic [IDX_W-1:0]                     o_index,
  input  logic                                 i_ready,
  output logic                                 o_err
);

  localparam int WC_W = $clog2(FRAME + 1);
  localparam int PA_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int CA_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, state_next;

  logic [PIX_WIDTH-1:0] mem [1<<CA_W][1<<PA_W];

  logic [WC_W-1:0]      wr_cnt;
  logic [WC_W-1:0]      pos;
  logic                 frame_done;
  logic                 wr_en;
  logic                 err_det;
  logic                 beat;
  logic                 xfer;
  logic                 out_load;
  logic                 rd_en;

  logic [IDX_W-1:0]     rd_idx;
  logic [PA_W-1:0]      rd_pix;
  logic [CA_W-1:0]      rd_ch;
  logic                 rd_done;

  // read-ahead stage: RAM output register feeding the output register
  logic                 r_valid;
  logic [PIX_WIDTH-1:0] ram_q;
  logic [IDX_W-1:0]     r_idx;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  // next-state logic; a sop beat always writes pixel 0 so restart and first
  // pixel share one path, and frame completion is judged on the written slot
  always_comb begin
    state_next = state;
    err_det    = 1'b0;
    wr_en      = 1'b0;
    pos        = i_sop ? '0 : wr_cnt;
    frame_done = ((pos + WC_W'(1)) == WC_W'(FRAME));
    case (state)
      IDLE, FILL: begin
        if (beat && (state == FILL || i_sop)) begin
          wr_en = 1'b1;
          if (i_eop) begin
            if (frame_done) begin
              state_next = DRAIN;
            end else begin
              err_det    = 1'b1;
              state_next = IDLE;
            end
          end else if (frame_done) begin
            err_det    = 1'b1;
            state_next = DRAIN;
          end else begin
            err_det    = (state == FILL) && i_sop;
            state_next = FILL;
          end
        end
      end
      DRAIN:   if (xfer && o_eop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // output / handshake decode
  always_comb begin
    o_ready  = (state != DRAIN);
    beat     = clk_en && i_valid && o_ready;
    xfer     = clk_en && o_valid && i_ready;
    out_load = !o_valid || i_ready;
    rd_en    = (state == DRAIN) && !rd_done && (!r_valid || out_load);
  end

  // frame RAM: all channels of a pixel written in one beat
  always_ff @(posedge clk) begin
    if (clk_en && wr_en) begin
      for (int unsigned c = 0; c < DIMENSION; c++) begin
        mem[CA_W'(c)][pos[PA_W-1:0]] <= i_data[CA_W'(c)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_idx  <= '0;
      rd_pix  <= '0;
      rd_ch   <= '0;
      rd_done <= 1'b0;
      r_valid <= 1'b0;
      ram_q   <= '0;
      r_idx   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_index <= '0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_err   <= 1'b0;
    end else if (clk_en) begin
      o_err <= err_det;

      if (state_next == IDLE) wr_cnt <= '0;
      else if (wr_en)         wr_cnt <= pos + WC_W'(1);

      if (state != DRAIN) begin
        rd_idx  <= '0;
        rd_pix  <= '0;
        rd_ch   <= '0;
        rd_done <= 1'b0;
        r_valid <= 1'b0;
      end else if (rd_en) begin
        // the RAM is only read when the read-ahead slot is free or moving on,
        // so a stalled output never loses the element behind it
        ram_q   <= mem[rd_ch][rd_pix];
        r_idx   <= rd_idx;
        r_valid <= 1'b1;
        if (rd_idx == IDX_W'(TOTAL - 1)) begin
          rd_done <= 1'b1;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
          if (rd_pix == PA_W'(FRAME - 1)) begin
            rd_pix <= '0;
            rd_ch  <= rd_ch + CA_W'(1);
          end else begin
            rd_pix <= rd_pix + PA_W'(1);
          end
        end
      end else if (out_load) begin
        r_valid <= 1'b0;
      end

      if (out_load) begin
        o_valid <= r_valid;
        o_sop   <= r_valid && (r_idx == '0);
        o_eop   <= r_valid && (r_idx == IDX_W'(TOTAL - 1));
        if (r_valid) begin
          o_data  <= ram_q;
          o_index <= r_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_flatten_serializer_block.sv
module tb_flatten_serializer_block;
  localparam int P     = 8;
  localparam int W     = 2;
  localparam int H     = 2;
  localparam int D     = 2;
  localparam int FRAME = W * H;
  localparam int TOTAL = D * FRAME;
  localparam int IW    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_en;
  logic [D-1:0][P-1:0] i_data;
  logic              i_valid, i_sop, i_eop, i_ready;
  logic              o_ready, o_valid, o_sop, o_eop, o_err;
  logic [P-1:0]      o_data;
  logic [IW-1:0]     o_index;

  always #5 clk = ~clk;

  flatten_serializer_block #(
    .PIX_WIDTH (P),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DIMENSION (D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_sop  (i_sop),
    .i_eop  (i_eop),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_sop  (o_sop),
    .o_eop  (o_eop),
    .o_index(o_index),
    .i_ready(i_ready),
    .o_err  (o_err)
  );

  typedef struct {
    logic [P-1:0] d;
    int           idx;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           pops = 0;
  int           err_seen = 0;
  int           exp_err = 0;
  bit           strict = 0;
  int           final_cyc = 0;
  int           last_xfer_cyc = 0;
  int           ready_mode = 0;
  logic [P-1:0] cur [FRAME][D];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // downstream ready generator
  initial begin
    int rp = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: begin
          i_ready = (rp == 0);
          rp = (rp + 1) % 3;
        end
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pops the scoreboard on every output transfer
  initial begin
    logic         hold_prev = 1'b0;
    logic [P-1:0] pd = '0;
    logic [IW-1:0] pi = '0;
    logic         ps = 1'b0, pe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        hold_prev = 1'b0;
      end else begin
        if (o_err === 1'b1) err_seen++;
        if (hold_prev)
          chk("hold_stable", {o_valid, o_data, o_index, o_sop, o_eop}, {1'b1, pd, pi, ps, pe});
        if (o_valid && i_ready && clk_en) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got data %0d index %0d, required no element", o_data, o_index);
          end else begin
            mon_e = sb.pop_front();
            pops++;
            chk("element", {o_data, o_index, o_sop, o_eop},
                {mon_e.d, IW'(mon_e.idx), mon_e.idx == 0, mon_e.idx == TOTAL - 1});
            if (strict) begin
              if (mon_e.idx == 0) chk("first_latency", cyc, final_cyc + 3);
              else                chk("no_gap", cyc, last_xfer_cyc + 1);
            end
          end
          last_xfer_cyc = cyc;
        end
        hold_prev = o_valid && !(i_ready && clk_en);
        pd = o_data;
        pi = o_index;
        ps = o_sop;
        pe = o_eop;
      end
    end
  end

  task automatic beat(input logic [D-1:0][P-1:0] d, input logic s, input logic e);
    i_valid = 1'b1;
    i_data  = d;
    i_sop   = s;
    i_eop   = e;
    tick();
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
  endtask

  task automatic fill_fixed();
    for (int p = 0; p < FRAME; p++)
      for (int c = 0; c < D; c++)
        cur[p][c] = P'(c * 10 + p + 1);
  endtask

  task automatic fill_rand();
    for (int p = 0; p < FRAME; p++)
      for (int c = 0; c < D; c++)
        cur[p][c] = P'($urandom_range(0, 255));
  endtask

  // reference: element index ch*FRAME+p carries channel ch of pixel p
  task automatic send_frame(input bit gate, input bit noeop);
    logic [D-1:0][P-1:0] d;
    for (int ch = 0; ch < D; ch++)
      for (int p = 0; p < FRAME; p++)
        sb.push_back('{d: cur[p][ch], idx: ch * FRAME + p});
    for (int p = 0; p < FRAME; p++) begin
      for (int c = 0; c < D; c++) d[c] = cur[p][c];
      if (gate && p == 2) begin
        clk_en  = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        repeat (3) tick();
        chk("frozen_fill_ready", o_ready, 1);
        clk_en = 1'b1;
      end
      if (p == FRAME - 1) final_cyc = cyc;
      beat(d, p == 0, (p == FRAME - 1) && !noeop);
    end
  endtask

  task automatic drain(input bit gate, input bit corrupt);
    int n = 0;
    while (!(sb.size() == 0 && o_ready && !o_valid) && n < 300) begin
      if (gate && n == 4) begin
        clk_en = 1'b0;
        repeat (3) tick();
        clk_en = 1'b1;
      end
      if (corrupt && !o_ready) begin
        i_valid = 1'b1;
        i_data  = (D*P)'($urandom);
        i_sop   = 1'($urandom_range(0, 1));
        i_eop   = 1'($urandom_range(0, 1));
      end else begin
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
      end
      tick();
      n++;
    end
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    chk("drain_timeout", n >= 300, 0);
    chk("drain_left", sb.size(), 0);
  endtask

  function automatic logic [D*P-1:0] rnd();
    return (D*P)'($urandom);
  endfunction

  initial begin
    int n;
    int base;
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    i_valid = 1'b0;
    i_sop   = 1'b0;
    i_eop   = 1'b0;
    i_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_sop_eop_err", {o_sop, o_eop, o_err}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_index", o_index, 0);
    rst_n = 1'b1;
    tick();

    // basic frame, continuous ready: exact latency and no bubbles
    fill_fixed();
    strict = 1;
    send_frame(0, 0);
    drain(0, 0);
    strict = 0;
    chk("t1_no_err", err_seen, exp_err);

    // backpressure pattern 1,0,0
    ready_mode = 1;
    send_frame(0, 0);
    drain(0, 0);
    ready_mode = 0;

    // early eop on beat 3
    beat(rnd(), 1, 0);
    beat(rnd(), 0, 0);
    beat(rnd(), 0, 1);
    exp_err++;
    repeat (3) tick();
    chk("early_eop_err", err_seen, exp_err);
    chk("early_eop_no_valid", o_valid, 0);
    chk("early_eop_ready", o_ready, 1);
    fill_rand();
    send_frame(0, 0);
    drain(0, 0);

    // sop in the middle of a fill restarts the frame
    beat(rnd(), 1, 0);
    beat(rnd(), 0, 0);
    fill_rand();
    send_frame(0, 0);
    exp_err++;
    drain(0, 0);
    chk("restart_err", err_seen, exp_err);

    // missing eop on the last pixel still drains
    fill_rand();
    send_frame(0, 1);
    exp_err++;
    drain(0, 0);
    chk("missing_eop_err", err_seen, exp_err);

    // sop and eop together on a multi-pixel frame
    beat(rnd(), 1, 1);
    exp_err++;
    repeat (2) tick();
    chk("sop_eop_err", err_seen, exp_err);
    chk("sop_eop_ready", o_ready, 1);
    chk("sop_eop_no_valid", o_valid, 0);

    // beats without sop while idle are ignored silently
    beat(rnd(), 0, 0);
    beat(rnd(), 0, 1);
    tick();
    chk("idle_nosop_no_err", err_seen, exp_err);
    fill_fixed();
    send_frame(0, 0);
    drain(0, 0);

    // corrupt beats while draining
    fill_rand();
    send_frame(0, 0);
    drain(0, 1);

    // reset mid-drain after five elements
    fill_fixed();
    base = pops;
    send_frame(0, 0);
    n = 0;
    while (pops < base + 5 && n < 100) begin
      tick();
      n++;
    end
    chk("reset_wait_timeout", n >= 100, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {o_ready, o_valid, o_sop, o_eop, o_err, o_data, o_index}, {1'b1, 4'b0, 8'd0, 3'd0});
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fill_rand();
    send_frame(0, 0);
    drain(0, 0);

    // enable gaps mid-fill and mid-drain
    fill_fixed();
    send_frame(1, 0);
    drain(1, 0);

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      ready_mode = $urandom_range(0, 2);
      fill_rand();
      send_frame(k[0], 0);
      drain(k[1], k == 5);
    end
    ready_mode = 0;
    tick();
    chk("final_err_count", err_seen, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
